// File: rtl/seq_pkg.sv
// Shared types and encodings for the instruction sequencer: FSM state enum,
// opcode map, memory micro-instruction codes and the decoder's output bundle.
package seq_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    WAIT    = 3'd1,
    EXEC    = 3'd2,
    MEMWAIT = 3'd3,
    HALTED  = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_SJMP      = 4'h1;
  localparam logic [3:0] OP_JMP       = 4'h2;
  localparam logic [3:0] OP_LOAD      = 4'h3;
  localparam logic [3:0] OP_STORE     = 4'h4;
  localparam logic [3:0] OP_ALU_FIRST = 4'h5;
  localparam logic [3:0] OP_ALU_LAST  = 4'hE;
  localparam logic [3:0] OP_HLT       = 4'hF;

  // Codes shared with program_counter and the data memory.
  typedef logic [2:0] mem_ui_t;
  localparam mem_ui_t MEM_NONE  = 3'd0;
  localparam mem_ui_t MEM_SJMP  = 3'd1;
  localparam mem_ui_t MEM_JMP   = 3'd2;
  localparam mem_ui_t MEM_LOAD  = 3'd3;
  localparam mem_ui_t MEM_STORE = 3'd4;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: maps the fetched opcode to the control that
// the sequencer registers for its one-cycle EXEC slot.
module instr_decoder
  import seq_pkg::*;
(
  input  logic [3:0] opcode,
  output mem_ui_t    mem_ui,
  output logic       alu_en,
  output logic       ce_req,
  output logic       halt_req,
  output state_t     next_state
);

  // Opcode decode; anything not a jump, memory access or halt advances the PC.
  always_comb begin
    mem_ui     = MEM_NONE;
    alu_en     = 1'b0;
    ce_req     = 1'b0;
    halt_req   = 1'b0;
    next_state = FETCH;
    case (opcode)
      OP_NOP:   ce_req = 1'b1;
      OP_SJMP:  mem_ui = MEM_SJMP;
      OP_JMP:   mem_ui = MEM_JMP;
      OP_LOAD: begin
        mem_ui     = MEM_LOAD;
        next_state = MEMWAIT;
      end
      OP_STORE: begin
        mem_ui     = MEM_STORE;
        next_state = MEMWAIT;
      end
      OP_HLT: begin
        halt_req   = 1'b1;
        next_state = HALTED;
      end
      default: begin
        if (is_alu_op(opcode)) begin
          alu_en = 1'b1;
          ce_req = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute sequencer feeding program_counter.
// FETCH registers the ROM address, WAIT captures the ROM word into IR and
// registers the decoded EXEC control, EXEC drives it for exactly one cycle.
// Optional single-step gating of FETCH is built when SEQ_SINGLE_STEP_EN is defined.
module instruction_sequencer
  import seq_pkg::*;
#(
  parameter int WORD_W   = 4,
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 8,
  parameter int MEM_UI_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_W-1:0]     pc,
  output logic [PC_W-1:0]     rom_addr,
  input  logic [INSTR_W-1:0]  rom_data,
  input  logic                mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                step_mode,
  input  logic                step,
`endif
  output logic                ce,
  output logic                halt,
  output logic [WORD_W-1:0]   instruction_value,
  output logic [MEM_UI_W-1:0] mem_instruction,
  output logic [3:0]          alu_op,
  output logic                alu_en,
  output logic [2:0]          state_dbg
);

  state_t             state_reg;
  state_t             exec_next_reg;
  logic [INSTR_W-1:0] ir_reg;
  logic [PC_W-1:0]    rom_addr_reg;
  logic               ce_reg;
  logic               halt_reg;
  logic               alu_en_reg;
  mem_ui_t            mem_ui_reg;

  mem_ui_t dec_mem_ui;
  logic    dec_alu_en;
  logic    dec_ce_req;
  logic    dec_halt_req;
  state_t  dec_next_state;
  logic    fetch_go;
  logic    mem_done;

  // Decode the ROM word while it is being captured so EXEC outputs come from flops.
  instr_decoder u_decoder (
    .opcode     (rom_data[INSTR_W-1 -: 4]),
    .mem_ui     (dec_mem_ui),
    .alu_en     (dec_alu_en),
    .ce_req     (dec_ce_req),
    .halt_req   (dec_halt_req),
    .next_state (dec_next_state)
  );

`ifdef SEQ_SINGLE_STEP_EN
  assign fetch_go = !step_mode || step;
`else
  assign fetch_go = 1'b1;
`endif

  // Memory handshake completes in the MEMWAIT cycle that sees mem_ready, so the
  // PC increments on that edge and the following FETCH already sees the new pc.
  assign mem_done = (state_reg == MEMWAIT) && mem_ready;

  // Sequencer FSM and registered control; strobes default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= FETCH;
      exec_next_reg <= FETCH;
      ir_reg        <= '0;
      rom_addr_reg  <= '0;
      ce_reg        <= 1'b0;
      halt_reg      <= 1'b0;
      alu_en_reg    <= 1'b0;
      mem_ui_reg    <= MEM_NONE;
    end else begin
      ce_reg     <= 1'b0;
      alu_en_reg <= 1'b0;
      case (state_reg)
        FETCH: begin
          rom_addr_reg <= pc;
          if (fetch_go) state_reg <= WAIT;
        end
        WAIT: begin
          ir_reg        <= rom_data;
          ce_reg        <= dec_ce_req;
          alu_en_reg    <= dec_alu_en;
          halt_reg      <= dec_halt_req;
          mem_ui_reg    <= dec_mem_ui;
          exec_next_reg <= dec_next_state;
          state_reg     <= EXEC;
        end
        EXEC: begin
          // LOAD/STORE keep their micro-instruction through MEMWAIT.
          if (exec_next_reg != MEMWAIT) mem_ui_reg <= MEM_NONE;
          state_reg <= exec_next_reg;
        end
        MEMWAIT: begin
          if (mem_ready) begin
            mem_ui_reg <= MEM_NONE;
            state_reg  <= FETCH;
          end
        end
        HALTED: begin
          halt_reg <= 1'b1;
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign rom_addr          = rom_addr_reg;
  assign ce                = ce_reg || mem_done;
  assign halt              = halt_reg;
  assign alu_en            = alu_en_reg;
  assign alu_op            = alu_en_reg ? ir_reg[INSTR_W-1 -: 4] : 4'd0;
  assign instruction_value = ir_reg[WORD_W-1:0];
  assign mem_instruction   = MEM_UI_W'(mem_done ? MEM_NONE : mem_ui_reg);
  assign state_dbg         = state_reg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: directed programs in a ROM
// model, a program_counter model, expected EXEC/handshake responses queued
// by the stimulus and checked by an independent monitor.
module tb_instruction_sequencer;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       mem_ready;
  logic       ce;
  logic       halt;
  logic [3:0] instruction_value;
  logic [2:0] mem_instruction;
  logic [3:0] alu_op;
  logic       alu_en;
  logic [2:0] state_dbg;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step_mode;
  logic       step;
`endif

  logic [7:0] rom [256];
  // rom_addr is already a register, so the word is readable the cycle after FETCH.
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  instruction_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .pc                (pc),
    .rom_addr          (rom_addr),
    .rom_data          (rom_data),
    .mem_ready         (mem_ready),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode         (step_mode),
    .step              (step),
`endif
    .ce                (ce),
    .halt              (halt),
    .instruction_value (instruction_value),
    .mem_instruction   (mem_instruction),
    .alu_op            (alu_op),
    .alu_en            (alu_en),
    .state_dbg         (state_dbg)
  );

  typedef struct packed {
    logic       ce;
    logic       halt;
    logic       alu_en;
    logic [3:0] alu_op;
    logic [2:0] mem_ui;
    logic [3:0] iv;
    logic [7:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miss    = 0;

  task automatic expect_tx(input logic ce_e, input logic halt_e, input logic alu_en_e,
                           input logic [3:0] op_e, input logic [2:0] mui_e,
                           input logic [3:0] iv_e, input logic [7:0] addr_e);
    exp_t e;
    e.ce = ce_e; e.halt = halt_e; e.alu_en = alu_en_e; e.alu_op = op_e;
    e.mem_ui = mui_e; e.iv = iv_e; e.addr = addr_e;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: every EXEC cycle and every completing MEMWAIT cycle is a transaction.
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (state_dbg == 3'd2 || (state_dbg == 3'd3 && ce)) begin
          g.ce = ce; g.halt = halt; g.alu_en = alu_en; g.alu_op = alu_op;
          g.mem_ui = mem_instruction; g.iv = instruction_value; g.addr = rom_addr;
          vectors++;
          if (exp_q.size() == 0) begin
            miss++;
            $display("FAIL unexpected_tx got=%h state=%0d", g, state_dbg);
          end else begin
            e = exp_q.pop_front();
            if (g !== e)
              begin
                miss++;
                $display("FAIL tx got{ce,halt,alu_en,op,mem,iv,addr}=%b,%b,%b,%h,%0d,%h,%h exp=%b,%b,%b,%h,%0d,%h,%h",
                         g.ce, g.halt, g.alu_en, g.alu_op, g.mem_ui, g.iv, g.addr,
                         e.ce, e.halt, e.alu_en, e.alu_op, e.mem_ui, e.iv, e.addr);
              end
          end
        end
        if (ce && (mem_instruction == MEM_SJMP || mem_instruction == MEM_JMP)) begin
          miss++;
          $display("FAIL ce_with_jump got ce=%b mem=%0d exp ce=0", ce, mem_instruction);
        end
        if (ce && !(state_dbg == 3'd2 || state_dbg == 3'd3)) begin
          miss++;
          $display("FAIL ce_outside_exec got state=%0d exp EXEC or MEMWAIT", state_dbg);
        end
      end
    end
  end

  // program_counter model: increment on ce, load on SJMP/JMP (upper bus nibble = 3).
  initial begin
    logic       s_ce;
    logic [2:0] s_mi;
    logic [3:0] s_iv;
    forever begin
      @(negedge clk);
      s_ce = ce; s_mi = mem_instruction; s_iv = instruction_value;
      @(posedge clk);
      #1;
      if (!reset) begin
        if (s_ce)                  pc = pc + 8'd1;
        else if (s_mi == MEM_SJMP) pc = {pc[7:4], s_iv};
        else if (s_mi == MEM_JMP)  pc = {4'h3, s_iv};
      end
    end
  end

  task automatic reset_to(input logic [7:0] start_pc);
    reset = 1'b1;
    exp_q.delete();
    pc = start_pc;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (state_dbg != 3'd4 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("reach_halted", 32'(state_dbg), 32'd4);
  endtask

  task automatic drain(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ce_hist;
    logic [8:0] c6;
    int h, c, n, f, n_load;
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    reset = 1'b1;
    pc = 8'h00;
    mem_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b0;
    step = 1'b0;
`endif
    @(posedge clk);
    #1;
    chk("reset_outputs", {ce, halt, alu_en, alu_op, mem_instruction, instruction_value, rom_addr, state_dbg}, 32'd0);

    // NOP, ALU 5, ALU E (upper ALU boundary), HLT
    rom[8'h00] = 8'h00; rom[8'h01] = 8'h57; rom[8'h02] = 8'hE3; rom[8'h03] = 8'hF0;
    reset_to(8'h00);
    expect_tx(1, 0, 0, 4'h0, MEM_NONE, 4'h0, 8'h00);
    expect_tx(1, 0, 1, 4'h5, MEM_NONE, 4'h7, 8'h01);
    expect_tx(1, 0, 1, 4'hE, MEM_NONE, 4'h3, 8'h02);
    expect_tx(0, 1, 0, 4'h0, MEM_NONE, 4'h0, 8'h03);
    c6 = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ce_hist[i] = ce;
      if (i == 5) c6 = {alu_en, alu_op, instruction_value};
    end
    chk("ce_cycles_3_6", 32'(ce_hist), 32'b100100);
    chk("cycle6_alu_iv", 32'(c6), {23'd0, 1'b1, 4'h5, 4'h7});
    wait_halt(40);
    drain("drain_alu");
    h = 0; c = 0;
    repeat (20) begin
      @(negedge clk);
      if (halt) h++;
      if (ce) c++;
    end
    chk("halt_held_20", h, 20);
    chk("ce_while_halted", c, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_halt", {halt, state_dbg}, 32'd0);

    // SJMP then JMP then HLT
    rom[8'h12] = 8'h1A; rom[8'h1A] = 8'h2C; rom[8'h3C] = 8'hF0;
    reset_to(8'h12);
    expect_tx(0, 0, 0, 4'h0, MEM_SJMP, 4'hA, 8'h12);
    expect_tx(0, 0, 0, 4'h0, MEM_JMP,  4'hC, 8'h1A);
    expect_tx(0, 1, 0, 4'h0, MEM_NONE, 4'h0, 8'h3C);
    wait_halt(40);
    drain("drain_jumps");

    // PC wrap 0xFF -> 0x00
    rom[8'hFF] = 8'h05; rom[8'h00] = 8'hF0;
    reset_to(8'hFF);
    expect_tx(1, 0, 0, 4'h0, MEM_NONE, 4'h5, 8'hFF);
    expect_tx(0, 1, 0, 4'h0, MEM_NONE, 4'h0, 8'h00);
    wait_halt(40);
    drain("drain_wrap");

    // LOAD with 4 wait cycles, STORE with mem_ready already high in EXEC
    rom[8'h20] = 8'h36; rom[8'h21] = 8'h4B; rom[8'h22] = 8'hF0;
    mem_ready = 1'b0;
    reset_to(8'h20);
    expect_tx(0, 0, 0, 4'h0, MEM_LOAD,  4'h6, 8'h20);
    expect_tx(1, 0, 0, 4'h0, MEM_NONE,  4'h6, 8'h20);
    expect_tx(0, 0, 0, 4'h0, MEM_STORE, 4'hB, 8'h21);
    expect_tx(1, 0, 0, 4'h0, MEM_NONE,  4'hB, 8'h21);
    expect_tx(0, 1, 0, 4'h0, MEM_NONE,  4'h0, 8'h22);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_instruction != MEM_LOAD && n < 20);
    n_load = (mem_instruction == MEM_LOAD) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_instruction == MEM_LOAD) n_load++;
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("load_ready_cycle", {ce, mem_instruction}, {28'd0, 1'b1, MEM_NONE});
    chk("load_cycles", n_load, 5);
    wait_halt(40);
    mem_ready = 1'b0;
    drain("drain_mem");

    // Asynchronous reset in MEMWAIT with mem_ready rising at the same moment
    rom[8'h30] = 8'h39;
    reset_to(8'h30);
    expect_tx(0, 0, 0, 4'h0, MEM_LOAD, 4'h9, 8'h30);
    n = 0;
    while (state_dbg != 3'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("in_memwait", 32'(state_dbg), 32'd3);
    #2;
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("midcycle_reset_outputs",
        {ce, halt, alu_en, alu_op, mem_instruction, instruction_value, rom_addr, state_dbg}, 32'd0);
    drain("drain_reset_mem");
    c = 0;
    repeat (3) begin
      @(negedge clk);
      if (ce) c++;
    end
    chk("no_ce_in_reset", c, 0);
    mem_ready = 1'b0;

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: FETCH holds until a step pulse, one instruction per pulse
    rom[8'h40] = 8'h00; rom[8'h41] = 8'hF0;
    step_mode = 1'b1;
    step = 1'b0;
    reset_to(8'h40);
    expect_tx(1, 0, 0, 4'h0, MEM_NONE, 4'h0, 8'h40);
    f = 0;
    repeat (10) begin
      @(negedge clk);
      if (state_dbg == 3'd0) f++;
    end
    chk("step_hold_fetch", f, 10);
    @(posedge clk);
    #1;
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
    c = 0;
    repeat (12) begin
      @(negedge clk);
      if (ce) c++;
    end
    chk("step_one_ce", c, 1);
    chk("step_back_fetch", {state_dbg, rom_addr}, {21'd0, 3'd0, 8'h41});
    drain("drain_step");
    expect_tx(0, 1, 0, 4'h0, MEM_NONE, 4'h0, 8'h41);
    step_mode = 1'b0;
    wait_halt(40);
    drain("drain_step_halt");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Fetch/decode/execute sequencer sitting directly upstream of program_counter.
- Reads the program word at pc from synchronous program ROM and latches it into an instruction register (IR).
- Decodes the opcode and generates the per-instruction control that program_counter consumes: ce, halt, instruction_value, mem_instruction.
- Also drives ALU/memory micro-instructions to the datapath.

Parameters:
- WORD_W, 4, data word width; equals `WORD_SIZE.
- PC_W, 8, program counter width; equals `PC_SIZE.
- INSTR_W, 8, ROM word width: opcode in [7:4], immediate in [3:0].
- MEM_UI_W, 3, mem micro-instruction width; equals `MEM_MICRO_INSTRUCTION_SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc  in  PC_W  current program counter from program_counter.
- rom_addr  out  PC_W  program ROM address.
- rom_data  in  INSTR_W  ROM read data; valid one cycle after rom_addr is presented.
- mem_ready  in  1  data memory/bus ready for current LOAD/STORE.
- ce  out  1  one-cycle PC increment strobe.
- halt  out  1  PC freeze, level.
- instruction_value  out  WORD_W  IR immediate field.
- mem_instruction  out  MEM_UI_W  mem micro-instruction for program_counter and memory.
- alu_op  out  4  ALU opcode, valid while alu_en=1.
- alu_en  out  1  ALU execute strobe.
- state_dbg  out  3  current FSM state encoding.

Behaviour:
- Reset: asynchronous, active-high. While reset=1:
  - state=FETCH, IR=0.
  - ce=0, halt=0, alu_en=0, alu_op=0, mem_instruction=MEM_NONE.
  - rom_addr=0, instruction_value=0.
- rom_addr is a register loaded from pc in FETCH.
- FSM states: FETCH, WAIT, EXEC, MEMWAIT, HALTED.
- FETCH:
  - rom_addr<=pc; all strobes 0.
  - Next state: WAIT.
- WAIT:
  - IR<=rom_data.
  - Next state: EXEC.
- EXEC: outputs are registered and active for exactly one cycle; decode on IR[7:4].
  - NOP 0x0: ce=1; next FETCH.
  - SJMP 0x1: mem_instruction=MEM_SJMP, ce=0; next FETCH.
  - JMP 0x2: mem_instruction=MEM_JMP, ce=0; next FETCH. bus_in (upper PC bits) is supplied by the datapath in that same cycle.
  - LOAD 0x3 / STORE 0x4: mem_instruction=MEM_LOAD/MEM_STORE; next MEMWAIT.
  - ALU ops 0x5-0xE: alu_en=1, alu_op=IR[7:4], ce=1; next FETCH.
  - HLT 0xF: halt=1; next HALTED.
- MEMWAIT:
  - mem_instruction held.
  - When mem_ready=1: ce=1 for one cycle, mem_instruction=MEM_NONE; next FETCH.
  - mem_ready sampled in EXEC is ignored.
- HALTED:
  - halt=1 level, all other strobes 0.
  - Exit only via reset.
- instruction_value is always IR[3:0], combinational from IR.
- ce and jump never assert in the same cycle, so the PC is never both incremented and loaded.
- Throughput: 3 cycles per non-memory instruction; 3+N cycles for LOAD/STORE, where N = MEMWAIT cycles until mem_ready.
- PC wrap: 0xFF+1 wraps to 0x00 inside program_counter; the sequencer fetches 0x00 normally.
- Reset mid-instruction: any state returns to FETCH immediately; no partial strobe survives.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Enabled:
  - Adds inputs step_mode (1) and step (1).
  - With step_mode=1, FETCH holds (rom_addr still updated each cycle) until step is sampled 1, then advances.
  - Exactly one instruction executes per step pulse; step held high runs one instruction per FETCH visit.
  - step_mode=0 behaves as disabled.
- Disabled: ports absent; FETCH always advances.

Decomposition:
- Package seq_pkg holds:
  - state enum: FETCH=0, WAIT=1, EXEC=2, MEMWAIT=3, HALTED=4.
  - opcode constants OP_NOP..OP_HLT.
  - mem micro-instruction codes MEM_NONE=0, MEM_SJMP=1, MEM_JMP=2, MEM_LOAD=3, MEM_STORE=4; these must match defines.vh values.
- Sub-module: instr_decoder, purely combinational, IR opcode to {mem_ui, alu_en, ce_req, halt_req, next_state}. The FSM/register shell stays in instruction_sequencer.

Test Plan:
- ROM[0]=0x00, ROM[1]=0x57, pc stepping 0->1 -> ce pulses in cycles 3 and 6; alu_en=1 with alu_op=5 in cycle 6; instruction_value=7 in cycle 6.
- ROM[pc=0x12]=0x1A -> EXEC cycle: mem_instruction=MEM_SJMP, instruction_value=0xA, ce=0; next FETCH presents rom_addr=pc.
- ROM[0x20]=0x36, mem_ready held 0 for 4 cycles then 1 -> mem_instruction=MEM_LOAD for 5 cycles, single ce pulse on the ready cycle, then FETCH.
- ROM[pc]=0xF0 -> halt=1 from EXEC onward, held for 20+ cycles; ce never asserts. Pulse reset -> halt=0, state_dbg=FETCH asynchronously.
- Assert reset during MEMWAIT (mid-cycle, between edges) -> all outputs 0/MEM_NONE immediately, no ce pulse.
- SEQ_SINGLE_STEP_EN, step_mode=1: no step for 10 cycles -> state_dbg stays FETCH. One step pulse -> exactly one instruction retires (one ce).
